// File: rtl/adder_result_fifo.sv
// adder_result_fifo: circular FIFO buffering {carry, sum} results from the
// 4-bit adder between a valid/ready producer and a valid/ready consumer.
// Show-ahead read: the head entry is presented combinationally from the
// registered array. Pushes while full are dropped and latch a sticky
// overflow flag.
// Optional build macro: ADDER_FIFO_DROP_CNT_EN adds an 8-bit saturating
// drop_cnt output counting dropped pushes.
module adder_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
`ifdef ADDER_FIFO_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;

    // Handshake flags derive from registered count only, so there is no
    // combinational path from in_valid to out_valid or out_ready to in_ready.
    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        drop      = in_valid && full;
        out_data  = mem[rd_ptr];
    end

    // Storage array: written on an accepted push; a flush in the same cycle
    // wins, so the pushed value is discarded. Contents are never cleared.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and sticky overflow. DEPTH is a power of two, so
    // the pointers wrap by natural overflow of their AW-bit width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef ADDER_FIFO_DROP_CNT_EN
    // Saturating count of dropped pushes, flushed with the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (clr) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Self-checking bench for adder_result_fifo: a queue-based reference model
// is compared against the DUT at every falling edge, with directed scenarios
// that also pin outputs to hand-computed literals, followed by random traffic.
module tb_adder_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [2:0]       count;
    logic             overflow;
`ifdef ADDER_FIFO_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 1'b0;
    int               m_drop = 0;

    adder_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count),
`ifdef ADDER_FIFO_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue, updated from the inputs present at
    // each rising edge; cleared by reset or flush.
    always @(posedge clk or negedge rst_n) begin : model
        bit was_full;
        bit do_pop;
        if (!rst_n || clr) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = (mq.size() > 0) && out_ready;
            if (in_valid && was_full) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            if (do_pop) void'(mq.pop_front());
            if (in_valid && !was_full) mq.push_back(in_data);
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < DEPTH});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("count",     {29'd0, count},     mq.size());
            chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
            if (mq.size() > 0) chk("out_data", {27'd0, out_data}, {27'd0, mq[0]});
`ifdef ADDER_FIFO_DROP_CNT_EN
            chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
`endif
        end
    end

    // Advance one clock; returns just after the falling edge.
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drive(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit c);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
    endtask

    logic [WIDTH-1:0] pat [4];
    logic [WIDTH-1:0] head_exp;

    initial begin
        pat[0] = 5'h01; pat[1] = 5'h0F; pat[2] = 5'h10; pat[3] = 5'h1E;

        // Reset state
        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count",     {29'd0, count},     32'd0);
        chk("rst_overflow",  {31'd0, overflow},  32'd0);
`ifdef ADDER_FIFO_DROP_CNT_EN
        chk("rst_drop_cnt",  {24'd0, drop_cnt},  32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Single push, held while consumer stalls
        drive(1, 5'h13, 0, 0);
        cyc();
        drive(0, 5'h00, 0, 0);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data",  {27'd0, out_data},  32'h13);
        chk("t1_count", {29'd0, count},     32'd1);
        cyc(2);
        chk("t1_hold",  {27'd0, out_data},  32'h13);
        drive(0, 5'h00, 1, 0);
        cyc();
        chk("t1_empty", {31'd0, out_valid}, 32'd0);

        // Fill to DEPTH, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, pat[i], 0, 0);
            cyc();
        end
        drive(0, 5'h00, 0, 0);
        chk("t2_count", {29'd0, count},    32'd4);
        chk("t2_ready", {31'd0, in_ready}, 32'd0);
        chk("t2_model", mq.size(),         32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", {27'd0, out_data}, {27'd0, pat[i]});
            drive(0, 5'h00, 1, 0);
            cyc();
        end
        drive(0, 5'h00, 0, 0);
        chk("t2_count0", {29'd0, count},     32'd0);
        chk("t2_valid0", {31'd0, out_valid}, 32'd0);

        // Fill, then three dropped pushes while full
        for (int i = 0; i < 4; i++) begin
            drive(1, pat[i], 0, 0);
            cyc();
        end
        drive(1, 5'h1F, 0, 0);
        cyc(3);
        drive(0, 5'h00, 0, 0);
        chk("t3_ovf",   {31'd0, overflow}, 32'd1);
        chk("t3_count", {29'd0, count},    32'd4);
        chk("t3_head",  {27'd0, out_data}, 32'h01);
`ifdef ADDER_FIFO_DROP_CNT_EN
        chk("t3_drop",  {24'd0, drop_cnt}, 32'd3);
`endif

        // Drain to 2, then stream with simultaneous push/pop (pointers wrap)
        drive(0, 5'h00, 1, 0);
        cyc(2);
        chk("t4_head", {27'd0, out_data}, 32'h10);
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'($urandom_range(0, 31)), 1, 0);
            cyc();
            chk("t4_count", {29'd0, count}, 32'd2);
        end

        // Flush with a simultaneous push and pop at count=3
        drive(1, 5'h0A, 0, 0);
        cyc();
        chk("t5_count3", {29'd0, count}, 32'd3);
        drive(1, 5'h15, 1, 1);
        cyc();
        drive(0, 5'h00, 0, 0);
        chk("t5_count", {29'd0, count},     32'd0);
        chk("t5_ovf",   {31'd0, overflow},  32'd0);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle with count=2
        drive(1, 5'h07, 0, 0);
        cyc(2);
        drive(0, 5'h00, 0, 0);
        chk("t6_count2", {29'd0, count}, 32'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_count", {29'd0, count},     32'd0);
        chk("t6_ready", {31'd0, in_ready},  32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Random traffic, with phases biased toward full and toward empty
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            in_valid  = ($urandom_range(0, 3) != 0) ^ (bias == 2);
            out_ready = (bias == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            in_data   = 5'($urandom_range(0, 31));
            clr       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        drive(0, 5'h00, 0, 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
